// File: rtl/target_ddr_rx_deser.sv
// HDR-DDR target receive deserializer: samples SDA on both SCL edges, assembles
// preamble / command / data / CRC fields, checks parity, CRC token and CRC5.
module target_ddr_rx_deser #(
    parameter int         WORD_W      = 16,
    parameter logic [6:0] TARGET_ADDR = 7'h66,
    parameter logic [6:0] BCAST_ADDR  = 7'h7E,
    parameter logic [4:0] CRC_INIT    = 5'h1F
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_rx_en,
    input  logic [1:0]        i_rx_mode,
    input  logic              i_scl_pos_edge,
    input  logic              i_scl_neg_edge,
    input  logic              i_sda,
    input  logic              i_crc_clr,
    output logic              o_done,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid,
    output logic [1:0]        o_pre,
    output logic              o_rnw,
    output logic [1:0]        o_addr_match,
    output logic [2:0]        o_err,
    output logic [4:0]        o_crc_calc
);

    localparam int SR_W  = WORD_W + 1;
    localparam int CNT_W = $clog2(WORD_W + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [4:0]        crc_q, crc_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wvalid_q, wvalid_d;
    logic [1:0]        pre_q, pre_d;
    logic              rnw_q, rnw_d;
    logic [1:0]        amatch_q, amatch_d;
    logic [2:0]        err_q, err_d;

    logic              sample;
    logic              start;
    logic [1:0]        cur_mode;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  last_idx;
    logic [4:0]        crc_base;
    logic [WORD_W+1:0] field;
    logic [1:0]        par_calc;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = c[4] ^ b;
        return {c[3:0], 1'b0} ^ {2'b00, fb, 1'b0, fb};
    endfunction

    assign sample   = (i_scl_pos_edge | i_scl_neg_edge) & i_rx_en;
    assign start    = sample && (state_q != S_SHIFT);
    assign cur_mode = start ? i_rx_mode : mode_q;
    assign idx      = start ? '0 : cnt_q;
    // The bit being sampled this cycle completes the field view.
    assign field    = {sr_q, i_sda};

    always_comb begin
        case (cur_mode)
            2'b00:   last_idx = CNT_W'(1);
            2'b11:   last_idx = CNT_W'(8);
            default: last_idx = CNT_W'(WORD_W + 1);
        endcase
    end

    always_comb begin
        logic [WORD_W-1:0] w;
        logic              p_odd;
        logic              p_even;
        w      = field[WORD_W+1:2];
        p_odd  = 1'b0;
        p_even = 1'b0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            if (i[0]) p_odd  = p_odd ^ w[i];
            else      p_even = p_even ^ w[i];
        end
        par_calc = {p_odd, ~p_even};
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        done_d   = 1'b0;
        word_d   = word_q;
        wvalid_d = 1'b0;
        pre_d    = pre_q;
        rnw_d    = rnw_q;
        amatch_d = amatch_q;
        err_d    = err_q;

        crc_base = (i_crc_clr || (start && i_rx_mode == 2'b01)) ? CRC_INIT : crc_q;
        crc_d    = crc_base;

        if (!i_rx_en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (sample) begin
            sr_d   = {sr_q[SR_W-2:0], i_sda};
            mode_d = cur_mode;
            if ((cur_mode == 2'b01 || cur_mode == 2'b10) && idx < CNT_W'(WORD_W))
                crc_d = crc5_step(crc_base, i_sda);
            if (idx == last_idx) begin
                // Results are registered together with the done pulse.
                state_d = S_DONE;
                cnt_d   = '0;
                done_d  = 1'b1;
                case (cur_mode)
                    2'b00: begin
                        pre_d = field[1:0];
                        err_d = '0;
                    end
                    2'b11: begin
                        err_d = {field[4:0] != crc_q, field[8:5] != 4'hC, 1'b0};
                    end
                    default: begin
                        word_d   = field[WORD_W+1:2];
                        wvalid_d = 1'b1;
                        err_d    = {2'b00, field[1:0] != par_calc};
                        if (cur_mode == 2'b01) begin
                            rnw_d = field[WORD_W+1];
                            if (field[9:3] == TARGET_ADDR)     amatch_d = 2'b01;
                            else if (field[9:3] == BCAST_ADDR) amatch_d = 2'b10;
                            else                               amatch_d = 2'b00;
                        end
                    end
                endcase
            end else begin
                state_d = S_SHIFT;
                cnt_d   = idx + CNT_W'(1);
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            cnt_q    <= '0;
            sr_q     <= '0;
            crc_q    <= CRC_INIT;
            done_q   <= 1'b0;
            word_q   <= '0;
            wvalid_q <= 1'b0;
            pre_q    <= '0;
            rnw_q    <= 1'b0;
            amatch_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            crc_q    <= crc_d;
            done_q   <= done_d;
            word_q   <= word_d;
            wvalid_q <= wvalid_d;
            pre_q    <= pre_d;
            rnw_q    <= rnw_d;
            amatch_q <= amatch_d;
            err_q    <= err_d;
        end
    end

    assign o_done       = done_q;
    assign o_word       = word_q;
    assign o_word_valid = wvalid_q;
    assign o_pre        = pre_q;
    assign o_rnw        = rnw_q;
    assign o_addr_match = amatch_q;
    assign o_err        = err_q;
    assign o_crc_calc   = crc_q;

endmodule
